// File: rtl/bfp_pkg.sv
// Shared definitions for the block-floating-point normalizer: exponent width,
// frame error codes, FSM state types and the redundant-sign-bit counter.
package bfp_pkg;

    localparam int unsigned EXP_W = 6;

    localparam logic [1:0] ERR_UPSTREAM = 2'b01;
    localparam logic [1:0] ERR_OVERLEN  = 2'b10;

    typedef enum logic {W_IDLE, W_FILL}   wr_state_t;
    typedef enum logic {R_IDLE, R_STREAM} rd_state_t;

    // Bits below the MSB of a 32-bit value that repeat its sign (0..31).
    // Callers sign-extend narrower samples and subtract the extension length.
    function automatic logic [5:0] redundant_sign_bits(input logic [31:0] x);
        logic [5:0] n;
        logic       run;
        n   = '0;
        run = 1'b1;
        for (int unsigned i = 0; i < 31; i++) begin
            if (run && (x[30-i] == x[31])) begin
                n = n + 6'd1;
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bfp_frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// The address MSB selects the ping-pong bank.
module bfp_frame_ram #(
    parameter int unsigned DEPTH = 2048,
    parameter int unsigned WIDTH = 34
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bfp_normalizer.sv
// Block-floating-point encoder: buffers a complex frame in a ping-pong RAM,
// finds its headroom and emits shifted mantissas plus one shared exponent.
module bfp_normalizer
    import bfp_pkg::*;
#(
    parameter int unsigned IN_W      = 17,
    parameter int unsigned MANT_W    = 16,
    parameter int          EXP_MAX   = 2,
    parameter int unsigned MAX_FRAME = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sink_valid,
    output logic              sink_ready,
    input  logic              sink_sop,
    input  logic              sink_eop,
    input  logic [IN_W-1:0]   sink_real,
    input  logic [IN_W-1:0]   sink_imag,
    input  logic [1:0]        sink_error,
    input  logic              source_ready,
    output logic              source_valid,
    output logic              source_sop,
    output logic              source_eop,
    output logic [MANT_W-1:0] source_real,
    output logic [MANT_W-1:0] source_imag,
    output logic [EXP_W-1:0]  source_exp,
    output logic [1:0]        source_error
);

    localparam int          EXP_MIN = int'(MANT_W) - int'(IN_W);
    localparam int unsigned AW      = $clog2(MAX_FRAME);
    localparam int unsigned LW      = AW + 1;
    localparam int unsigned DW      = 2 * IN_W;

    typedef struct packed {
        logic              sop;
        logic              eop;
        logic [MANT_W-1:0] re;
        logic [MANT_W-1:0] im;
        logic [EXP_W-1:0]  ex;
        logic [1:0]        err;
    } beat_t;

    function automatic logic [5:0] sample_rsb(input logic [IN_W-1:0] x);
        return redundant_sign_bits({{(32-IN_W){x[IN_W-1]}}, x}) - 6'(32 - IN_W);
    endfunction

    function automatic logic [MANT_W-1:0] normalise(input logic [IN_W-1:0] x,
                                                    input logic [EXP_W-1:0] e);
        logic signed [31:0] xs;
        logic signed [31:0] ys;
        logic [EXP_W-1:0]   sh;
        xs = signed'({{(32-IN_W){x[IN_W-1]}}, x});
        sh = e[EXP_W-1] ? (EXP_W'(~e) + EXP_W'(1)) : e;
        ys = e[EXP_W-1] ? (xs >>> sh) : (xs <<< sh);
        return ys[MANT_W-1:0];
    endfunction

    // ---------------- writer ----------------
    wr_state_t        w_state, w_state_nx;
    logic             wbank;
    logic [AW-1:0]    waddr;
    logic [5:0]       r_min;
    logic [1:0]       w_err;

    logic             bank_full [2];
    logic [LW-1:0]    bank_len  [2];
    logic [EXP_W-1:0] bank_exp  [2];
    logic [1:0]       bank_err  [2];

    logic             accept;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic             close;
    logic [LW-1:0]    close_len;
    logic [1:0]       close_err;
    logic [EXP_W-1:0] close_exp;
    logic [5:0]       r_re, r_im, r_cur;
    logic [5:0]       frame_r_min;
    logic [1:0]       frame_err;
    int               exp_i;

    // Banks fill and drain strictly alternately, so the writer's next bank is
    // always the one the reader frees first.
    assign sink_ready = !reset && !bank_full[wbank];
    assign accept     = sink_valid && sink_ready;

    assign r_re  = sample_rsb(sink_real);
    assign r_im  = sample_rsb(sink_imag);
    assign r_cur = (r_re < r_im) ? r_re : r_im;

    always_comb begin
        w_state_nx  = w_state;
        wr_en       = 1'b0;
        wr_addr     = waddr;
        close       = 1'b0;
        close_len   = '0;
        close_err   = '0;
        frame_r_min = r_cur;
        frame_err   = sink_error;
        if (accept) begin
            if (sink_sop) begin
                wr_en   = 1'b1;
                wr_addr = '0;
                if (sink_eop) begin
                    close      = 1'b1;
                    close_len  = LW'(1);
                    close_err  = frame_err;
                    w_state_nx = W_IDLE;
                end else begin
                    w_state_nx = W_FILL;
                end
            end else if (w_state == W_FILL) begin
                wr_en       = 1'b1;
                frame_r_min = (r_cur < r_min) ? r_cur : r_min;
                frame_err   = w_err | sink_error;
                if (sink_eop) begin
                    close      = 1'b1;
                    close_len  = LW'(waddr) + LW'(1);
                    close_err  = frame_err;
                    w_state_nx = W_IDLE;
                end else if (waddr == AW'(MAX_FRAME - 1)) begin
                    close      = 1'b1;
                    close_len  = LW'(MAX_FRAME);
                    close_err  = frame_err | ERR_OVERLEN;
                    w_state_nx = W_IDLE;
                end
            end
        end
    end

    always_comb begin
        exp_i = int'(frame_r_min) - (int'(IN_W) - int'(MANT_W));
        if (exp_i > EXP_MAX) exp_i = EXP_MAX;
        if (exp_i < EXP_MIN) exp_i = EXP_MIN;
        close_exp = EXP_W'(exp_i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state <= W_IDLE;
            wbank   <= 1'b0;
            waddr   <= '0;
            r_min   <= '0;
            w_err   <= '0;
        end else begin
            w_state <= w_state_nx;
            if (wr_en) begin
                waddr <= wr_addr + AW'(1);
                r_min <= frame_r_min;
                w_err <= frame_err;
            end
            if (close) begin
                wbank <= ~wbank;
                waddr <= '0;
            end
        end
    end

    // ---------------- reader ----------------
    rd_state_t        r_state, r_state_nx;
    logic             rbank;
    logic [AW-1:0]    raddr;
    logic             rd_issue;
    logic             rd_last;
    logic             release_bank;
    logic             room;
    logic [1:0]       n_held;
    logic             pop;

    logic             out_valid, skid_valid, p_valid;
    beat_t            out_q, skid_q, p_beat;
    logic             p_sop, p_eop;
    logic [EXP_W-1:0] p_exp;
    logic [1:0]       p_err;
    logic [DW-1:0]    ram_rdata;

    // Issue a read only if its data will find a free slot in output/skid
    // even when the consumer stalls on the cycle it arrives.
    assign pop    = out_valid && source_ready;
    assign n_held = 2'(out_valid) + 2'(skid_valid) + 2'(p_valid) - 2'(pop);
    assign room   = (n_held <= 2'd1);

    assign rd_issue     = bank_full[rbank] && room;
    assign rd_last      = ({1'b0, raddr} == (bank_len[rbank] - LW'(1)));
    assign release_bank = rd_issue && rd_last;

    always_comb begin
        r_state_nx = r_state;
        if (rd_issue) begin
            r_state_nx = rd_last ? R_IDLE : R_STREAM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= R_IDLE;
            rbank   <= 1'b0;
            raddr   <= '0;
            p_valid <= 1'b0;
            p_sop   <= 1'b0;
            p_eop   <= 1'b0;
            p_exp   <= '0;
            p_err   <= '0;
        end else begin
            r_state <= r_state_nx;
            p_valid <= rd_issue;
            if (rd_issue) begin
                p_sop <= (r_state == R_IDLE);
                p_eop <= rd_last;
                p_exp <= bank_exp[rbank];
                p_err <= bank_err[rbank];
                raddr <= rd_last ? '0 : raddr + AW'(1);
                if (rd_last) begin
                    rbank <= ~rbank;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned b = 0; b < 2; b++) begin
                bank_full[b] <= 1'b0;
                bank_len[b]  <= '0;
                bank_exp[b]  <= '0;
                bank_err[b]  <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < 2; b++) begin
                if (close && (wbank == 1'(b))) begin
                    bank_full[b] <= 1'b1;
                    bank_len[b]  <= close_len;
                    bank_exp[b]  <= close_exp;
                    bank_err[b]  <= close_err;
                end else if (release_bank && (rbank == 1'(b))) begin
                    bank_full[b] <= 1'b0;
                end
            end
        end
    end

    bfp_frame_ram #(
        .DEPTH (2 * MAX_FRAME),
        .WIDTH (DW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({wbank, wr_addr}),
        .wdata ({sink_real, sink_imag}),
        .re    (rd_issue),
        .raddr ({rbank, raddr}),
        .rdata (ram_rdata)
    );

    // ---------------- shifter, output register and skid ----------------
    always_comb begin
        p_beat     = '0;
        p_beat.sop = p_sop;
        p_beat.eop = p_eop;
        p_beat.re  = normalise(ram_rdata[DW-1:IN_W], p_exp);
        p_beat.im  = normalise(ram_rdata[IN_W-1:0], p_exp);
        p_beat.ex  = p_exp;
        p_beat.err = p_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else if (!out_valid || source_ready) begin
            out_valid <= skid_valid || p_valid;
            if (skid_valid) begin
                out_q      <= skid_q;
                skid_valid <= p_valid;
                if (p_valid) begin
                    skid_q <= p_beat;
                end
            end else if (p_valid) begin
                out_q <= p_beat;
            end
        end else if (p_valid) begin
            skid_q     <= p_beat;
            skid_valid <= 1'b1;
        end
    end

    assign source_valid = out_valid;
    assign source_sop   = out_q.sop;
    assign source_eop   = out_q.eop;
    assign source_real  = out_q.re;
    assign source_imag  = out_q.im;
    assign source_exp   = out_q.ex;
    assign source_error = out_q.err;

endmodule

// File: tb/tb_bfp_normalizer.sv
// Scoreboard bench for bfp_normalizer: directed frames push expected beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_bfp_normalizer;

    localparam int unsigned IN_W      = 17;
    localparam int unsigned MANT_W    = 16;
    localparam int unsigned MAX_FRAME = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              sink_valid, sink_ready, sink_sop, sink_eop;
    logic [IN_W-1:0]   sink_real, sink_imag;
    logic [1:0]        sink_error;
    logic              source_ready, source_valid, source_sop, source_eop;
    logic [MANT_W-1:0] source_real, source_imag;
    logic [5:0]        source_exp;
    logic [1:0]        source_error;

    always #5 clk = ~clk;

    bfp_normalizer #(
        .IN_W      (IN_W),
        .MANT_W    (MANT_W),
        .EXP_MAX   (2),
        .MAX_FRAME (MAX_FRAME)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sink_valid   (sink_valid),
        .sink_ready   (sink_ready),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_real    (sink_real),
        .sink_imag    (sink_imag),
        .sink_error   (sink_error),
        .source_ready (source_ready),
        .source_valid (source_valid),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_real  (source_real),
        .source_imag  (source_imag),
        .source_exp   (source_exp),
        .source_error (source_error)
    );

    typedef logic [41:0] beat_t;

    beat_t       exp_q[$];
    beat_t       dut_beat;
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    assign dut_beat = {source_sop, source_eop, source_real, source_imag, source_exp, source_error};

    function automatic beat_t mk(input logic s, input logic e, input int re, input int im,
                                 input int ex, input logic [1:0] er);
        return {s, e, 16'(re), 16'(im), 6'(ex), er};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic send(input logic s, input logic e, input int re, input int im,
                        input logic [1:0] er);
        int unsigned guard = 0;
        sink_valid = 1'b1;
        sink_sop   = s;
        sink_eop   = e;
        sink_real  = IN_W'(re);
        sink_imag  = IN_W'(im);
        sink_error = er;
        while (!sink_ready && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (!sink_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL sink_ready_timeout: got 0 after %0d cycles, want 1", guard);
        end
        @(negedge clk);
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        sink_error = 2'b00;
    endtask

    task automatic wait_drain(input string name);
        int unsigned guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check({name, "_idle"}, 64'(source_valid), 64'd0);
    endtask

    // Monitor: compares every accepted beat and checks hold-stability on stalls.
    initial begin
        beat_t held;
        logic  held_valid;
        beat_t want;
        held_valid = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                held_valid = 1'b0;
            end else begin
                if (held_valid) begin
                    check("stall_hold", 64'(dut_beat), 64'(held));
                    check("stall_valid", 64'(source_valid), 64'd1);
                end
                if (source_valid && source_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_beat: got %h, want no output", dut_beat);
                    end else begin
                        want = exp_q.pop_front();
                        check("beat", 64'(dut_beat), 64'(want));
                    end
                end
                held_valid = source_valid && !source_ready;
                held       = dut_beat;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        sink_valid   = 1'b0;
        sink_sop     = 1'b0;
        sink_eop     = 1'b0;
        sink_real    = '0;
        sink_imag    = '0;
        sink_error   = 2'b00;
        source_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sink_ready", 64'(sink_ready), 64'd0);
        check("rst_source_valid", 64'(source_valid), 64'd0);
        check("rst_source_fields", 64'(dut_beat), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'(sink_ready), 64'd1);

        // Stray samples in idle: eop-only and plain sample are dropped.
        send(1'b0, 1'b1, 12345, 0, 2'b00);
        send(1'b0, 1'b0, -4000, 7, 2'b00);

        // Test 1: small frame scaled up by 2^2, with latency check.
        exp_q.push_back(mk(1, 0, 400, 0, 2, 2'b00));
        exp_q.push_back(mk(0, 0, -12, 0, 2, 2'b00));
        exp_q.push_back(mk(0, 0, 0, 0, 2, 2'b00));
        exp_q.push_back(mk(0, 1, 200, 0, 2, 2'b00));
        send(1'b1, 1'b0, 100, 0, 2'b00);
        send(1'b0, 1'b0, -3, 0, 2'b00);
        send(1'b0, 1'b0, 0, 0, 2'b00);
        send(1'b0, 1'b1, 50, 0, 2'b00);
        check("latency_t0", 64'(source_valid), 64'd0);
        @(negedge clk);
        check("latency_t1", 64'(source_valid), 64'd0);
        @(negedge clk);
        check("latency_t2", 64'(source_valid), 64'd1);
        wait_drain("t1_drain");

        // Test 2: full-scale frame shifted right, upstream error on one sample.
        exp_q.push_back(mk(1, 0, -32768, 0, -1, 2'b01));
        exp_q.push_back(mk(0, 0, 32767, -1, -1, 2'b01));
        exp_q.push_back(mk(0, 0, 0, -1, -1, 2'b01));
        exp_q.push_back(mk(0, 1, 0, 1, -1, 2'b01));
        send(1'b1, 1'b0, -65536, 0, 2'b00);
        send(1'b0, 1'b0, 65535, -1, 2'b01);
        send(1'b0, 1'b0, 1, -2, 2'b00);
        send(1'b0, 1'b1, 0, 3, 2'b00);
        wait_drain("t2_drain");

        // Test 3: sop restart discards the partial frame; exp=0; all-zero frame.
        send(1'b1, 1'b0, -65536, 0, 2'b01);
        exp_q.push_back(mk(1, 0, 32767, -5, 0, 2'b00));
        exp_q.push_back(mk(0, 1, -32768, 7, 0, 2'b00));
        send(1'b1, 1'b0, 32767, -5, 2'b00);
        send(1'b0, 1'b1, -32768, 7, 2'b00);
        exp_q.push_back(mk(1, 0, 0, 0, 2, 2'b00));
        exp_q.push_back(mk(0, 0, 0, 0, 2, 2'b00));
        exp_q.push_back(mk(0, 1, 0, 0, 2, 2'b00));
        send(1'b1, 1'b0, 0, 0, 2'b00);
        send(1'b0, 1'b0, 0, 0, 2'b00);
        send(1'b0, 1'b1, 0, 0, 2'b00);
        wait_drain("t3_drain");

        // Test 4: 8-sample ramp (-3500..3500, exp 2) with toggling ready.
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(mk(k == 0, k == 7, (k * 1000 - 3500) * 4, k * 4, 2, 2'b00));
        end
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    send(k == 0, k == 7, k * 1000 - 3500, k, 2'b00);
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    source_ready = ~source_ready;
                end
                source_ready = 1'b1;
            end
        join
        wait_drain("t4_drain");

        // Test 5: three frames against a stalled sink; third waits for bank 0.
        source_ready = 1'b0;
        for (int k = 0; k < 4; k++) exp_q.push_back(mk(k == 0, k == 3, (k + 1) * 4, 0, 2, 2'b00));
        exp_q.push_back(mk(1, 0, -4000, 0, 2, 2'b00));
        exp_q.push_back(mk(0, 0, 40, 0, 2, 2'b00));
        exp_q.push_back(mk(0, 0, 80, 0, 2, 2'b00));
        exp_q.push_back(mk(0, 1, 120, 0, 2, 2'b00));
        exp_q.push_back(mk(1, 0, 32000, 0, 1, 2'b00));
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b00));
        exp_q.push_back(mk(0, 0, 0, 0, 1, 2'b00));
        exp_q.push_back(mk(0, 1, -2, 0, 1, 2'b00));
        for (int k = 0; k < 4; k++) send(k == 0, k == 3, k + 1, 0, 2'b00);
        send(1'b1, 1'b0, -1000, 0, 2'b00);
        send(1'b0, 1'b0, 10, 0, 2'b00);
        send(1'b0, 1'b0, 20, 0, 2'b00);
        send(1'b0, 1'b1, 30, 0, 2'b00);
        check("both_full_ready", 64'(sink_ready), 64'd0);
        repeat (5) @(negedge clk);
        check("both_full_ready_hold", 64'(sink_ready), 64'd0);
        fork
            begin
                send(1'b1, 1'b0, 16000, 0, 2'b00);
                send(1'b0, 1'b0, 0, 0, 2'b00);
                send(1'b0, 1'b0, 0, 0, 2'b00);
                send(1'b0, 1'b1, -1, 0, 2'b00);
            end
            begin
                repeat (3) @(negedge clk);
                source_ready = 1'b1;
            end
        join
        wait_drain("t5_drain");

        // Test 6: overlength frame force-closed at MAX_FRAME, 9th sample dropped.
        for (int k = 0; k < 8; k++) exp_q.push_back(mk(k == 0, k == 7, (k + 1) * 4, 0, 2, 2'b10));
        exp_q.push_back(mk(1, 0, 28, 0, 2, 2'b00));
        exp_q.push_back(mk(0, 1, -28, 0, 2, 2'b00));
        for (int k = 0; k < 9; k++) send(k == 0, 1'b0, k + 1, 0, 2'b00);
        send(1'b1, 1'b0, 7, 0, 2'b00);
        send(1'b0, 1'b1, -7, 0, 2'b00);
        wait_drain("t6_drain");

        // Reset mid-frame: partial frame must vanish.
        send(1'b1, 1'b0, 300, 0, 2'b00);
        send(1'b0, 1'b0, 301, 0, 2'b00);
        send(1'b0, 1'b0, 302, 0, 2'b00);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_sink_ready", 64'(sink_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_source_valid", 64'(source_valid), 64'd0);
        check("midrst_source_fields", 64'(dut_beat), 64'd0);

        // Single-sample frame after reset: sop and eop together.
        exp_q.push_back(mk(1, 1, 20, -12, 2, 2'b00));
        send(1'b1, 1'b1, 5, -3, 2'b00);
        wait_drain("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
